// File: rtl/bf16_product_normalizer_pkg.sv
// Shared constants, special-value classes and stage-1 payload for the BF16 product normalizer.
package bf16_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [15:0] QNAN     = 16'h7FC0;
  localparam int unsigned PROD_W   = 11;
  localparam int unsigned EXPS_W   = 10;

  typedef enum logic [1:0] {NORM, ZERO, INF, NAN} cls_e;

  typedef struct packed {
    logic [PROD_W-1:0]        r;
    logic signed [EXPS_W-1:0] e;
    logic                     s;
    cls_e                     cls;
  } s1_payload_t;

endpackage

// File: rtl/bf16_product_normalizer_rounder.sv
// Stage-2 normalize/round/exponent-adjust for the resolved product.
// BF16_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module bf16_rounder
  import bf16_pkg::*;
(
  input  logic [PROD_W-1:0]        r,
  input  logic signed [EXPS_W-1:0] e_in,
  output logic [6:0]               m,
  output logic signed [EXPS_W-1:0] e_out,
  output logic                     inexact
);

  logic [6:0]               m_raw;
  logic                     g;
  logic                     st;
  logic                     up;
  logic [7:0]               m_inc;
  logic signed [EXPS_W-1:0] e_n;

  always_comb begin
    // R[10]=R[9]=0 only appears with approximate mantissas; it takes the R[9] path.
    if (r[10]) begin
      m_raw = r[9:3];
      g     = r[2];
      st    = |r[1:0];
      e_n   = e_in + 10'sd1;
    end else begin
      m_raw = r[8:2];
      g     = r[1];
      st    = r[0];
      e_n   = e_in;
    end
`ifdef BF16_RNE_EN
    up = g & (st | m_raw[0]);
`else
    up = 1'b0;
`endif
    m_inc   = {1'b0, m_raw} + {7'd0, up};
    m       = m_inc[6:0];
    e_out   = m_inc[7] ? e_n + 10'sd1 : e_n;
    inexact = g | st;
  end

endmodule

// File: rtl/bf16_product_normalizer.sv
// BF16 product normalizer: resolves the CSA mantissa pair, normalizes, rounds and packs the
// result with {nan, ovf, unf, inexact} flags. Optional BF16_RNE_EN enables round-to-nearest-even.
module bf16_product_normalizer
  import bf16_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7,
  parameter int unsigned RES_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] mults,
  input  logic [RES_W-1:0] multc,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic [3:0]       flags
);

  logic        s1_valid;
  logic        s2_adv;
  s1_payload_t s1_d;
  s1_payload_t s1_q;

  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W-1:0] ma;
  logic [MAN_W-1:0] mb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  logic [6:0]               rnd_m;
  logic signed [EXPS_W-1:0] rnd_e;
  logic                     rnd_inexact;
  logic [15:0]              res_d;
  logic [3:0]               flags_d;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  assign ea = op_a[MAN_W +: EXP_W];
  assign eb = op_b[MAN_W +: EXP_W];
  assign ma = op_a[MAN_W-1:0];
  assign mb = op_b[MAN_W-1:0];

  always_comb begin
    a_nan  = (ea == EXP_MAX) && (ma != '0);
    b_nan  = (eb == EXP_MAX) && (mb != '0);
    a_inf  = (ea == EXP_MAX) && (ma == '0);
    b_inf  = (eb == EXP_MAX) && (mb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    s1_d.r = PROD_W'(mults + (multc << 1));
    s1_d.e = 10'(ea) + 10'(eb) - 10'(EXP_BIAS);
    s1_d.s = op_a[15] ^ op_b[15];
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      s1_d.cls = NAN;
    else if (a_inf || b_inf)
      s1_d.cls = INF;
    else if (a_zero || b_zero)
      s1_d.cls = ZERO;
    else
      s1_d.cls = NORM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid)
        s1_q <= s1_d;
    end
  end

  bf16_rounder u_rounder (
    .r       (s1_q.r),
    .e_in    (s1_q.e),
    .m       (rnd_m),
    .e_out   (rnd_e),
    .inexact (rnd_inexact)
  );

  // Special classes win over range checks; range checks use the post-rounding exponent.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (s1_q.cls)
      NAN: begin
        res_d   = QNAN;
        flags_d = 4'b1000;
      end
      INF:  res_d = {s1_q.s, EXP_MAX, 7'h00};
      ZERO: res_d = {s1_q.s, 15'h0000};
      default: begin
        if (rnd_e >= 10'sd255) begin
          res_d   = {s1_q.s, EXP_MAX, 7'h00};
          flags_d = 4'b0101;
        end else if (rnd_e <= 10'sd0) begin
          res_d   = {s1_q.s, 15'h0000};
          flags_d = 4'b0011;
        end else begin
          res_d   = {s1_q.s, rnd_e[7:0], rnd_m};
          flags_d = {3'b000, rnd_inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_d;
        flags  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_bf16_product_normalizer.sv
// Self-checking bench for bf16_product_normalizer: directed vectors, random traffic against
// an arithmetic reference model, backpressure and mid-stream reset.
module tb_bf16_product_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] mults;
  logic [10:0] multc;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  bf16_product_normalizer #(.EXP_W(8), .MAN_W(7), .RES_W(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mults     (mults),
    .multc     (multc),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Reference: value-level arithmetic on the resolved product, returns {flags, result}.
  function automatic logic [19:0] model(input logic [10:0] ms, input logic [10:0] mc,
                                        input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, r, e, sh, q, rem, half;
    logic s;
    logic inex;
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    ma = int'(a[6:0]);  mb = int'(b[6:0]);
    s  = a[15] ^ b[15];
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
      return {4'b1000, 16'h7FC0};
    if (ea == 255 || eb == 255) return {4'b0000, s, 8'hFF, 7'h00};
    if (ea == 0 || eb == 0)     return {4'b0000, s, 15'h0000};
    r = (int'(ms) + 2 * int'(mc)) % 2048;
    e = ea + eb - 127;
    if (r >= 1024) begin sh = 3; e = e + 1; end
    else sh = 2;
    q    = (r >> sh) % 128;
    rem  = r % (1 << sh);
    half = 1 << (sh - 1);
    inex = (rem != 0);
`ifdef BF16_RNE_EN
    if (rem > half || (rem == half && q % 2 == 1)) q = q + 1;
`endif
    if (q == 128) begin q = 0; e = e + 1; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 7'h00};
    if (e <= 0)   return {4'b0011, s, 15'h0000};
    return {3'b000, inex, s, 8'(e), 7'(q)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    int sel;
    v   = 16'($urandom);
    sel = $urandom_range(0, 15);
    if (sel == 0)      v[14:7] = 8'h00;
    else if (sel == 1) begin
      v[14:7] = 8'hFF;
      if ($urandom_range(0, 1) == 0) v[6:0] = 7'h00;
    end else           v[14:7] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  task automatic run_one(input logic [10:0] ms, input logic [10:0] mc,
                         input logic [15:0] a, input logic [15:0] b,
                         output logic [19:0] obs, output int lat);
    @(negedge clk);
    mults = ms; multc = mc; op_a = a; op_b = b;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    obs = {flags, result};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mults = '0; multc = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0 || flags !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b ir=%b res=%h fl=%h, want ov=0 ir=1 res=0000 fl=0",
               out_valid, in_ready, result, flags);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [10:0] dms[9] = '{11'h200, 11'h480, 11'h100, 11'h206, 11'h202,
                            11'h200, 11'h000, 11'h000, 11'h200};
    logic [10:0] dmc[9] = '{11'h000, 11'h000, 11'h080, 11'h000, 11'h000,
                            11'h000, 11'h000, 11'h000, 11'h000};
    logic [15:0] da[9]  = '{16'h3F80, 16'h3FC0, 16'h3F80, 16'h3F80, 16'h3F80,
                            16'h7F00, 16'h7FC1, 16'h7F80, 16'h0080};
    logic [15:0] db[9]  = '{16'h3F80, 16'h3FC0, 16'h3F80, 16'h3F80, 16'h3F80,
                            16'h7F00, 16'h3F80, 16'h0000, 16'h0080};
    logic [19:0] dexp[9];
    logic [19:0] obs;
    int lat;
    dexp[0] = {4'b0000, 16'h3F80};
    dexp[1] = {4'b0000, 16'h4010};
    dexp[2] = {4'b0000, 16'h3F80};
`ifdef BF16_RNE_EN
    dexp[3] = {4'b0001, 16'h3F82};
`else
    dexp[3] = {4'b0001, 16'h3F81};
`endif
    dexp[4] = {4'b0001, 16'h3F80};
    dexp[5] = {4'b0101, 16'h7F80};
    dexp[6] = {4'b1000, 16'h7FC0};
    dexp[7] = {4'b1000, 16'h7FC0};
    dexp[8] = {4'b0011, 16'h0000};
    for (int i = 0; i < 9; i++) begin
      run_one(dms[i], dmc[i], da[i], db[i], obs, lat);
      n_checks++;
      if (obs !== dexp[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: got fl=%h res=%h, want fl=%h res=%h",
                 i, obs[19:16], obs[15:0], dexp[i][19:16], dexp[i][15:0]);
      end
      n_checks++;
      if (lat != 2) begin
        n_fail++;
        $display("FAIL latency_%0d: got %0d cycles, want 2", i, lat);
      end
    end
  endtask

  task automatic test_random(input int cycles);
    logic [19:0] want;
    for (int c = 0; c < cycles + 40; c++) begin
      @(negedge clk);
      in_valid  = (c < cycles) && ($urandom_range(0, 9) < 7);
      out_ready = (c >= cycles) || ($urandom_range(0, 9) < 7);
      mults = 11'($urandom); multc = 11'($urandom);
      op_a = rand_op(); op_b = rand_op();
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_extra: got unexpected res=%h fl=%h, want no beat", result, flags);
        end else begin
          want = exp_q.pop_front();
          if ({flags, result} !== want) begin
            n_fail++;
            $display("FAIL random_beat: got fl=%h res=%h, want fl=%h res=%h",
                     flags, result, want[19:16], want[15:0]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(mults, multc, op_a, op_b));
    end
    in_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d beats outstanding, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [10:0] bm[3] = '{11'h200, 11'h300, 11'h2C4};
    logic [19:0] be[3];
    logic [15:0] held;
    int idx = 0;
    for (int i = 0; i < 3; i++) be[i] = model(bm[i], 11'h000, 16'h3F80, 16'h3F80);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (idx < 3);
      mults = bm[idx > 2 ? 2 : idx]; multc = '0; op_a = 16'h3F80; op_b = 16'h3F80;
      #1;
      if (in_valid && in_ready) idx++;
    end
    n_checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got accepted=%0d in_ready=%b, want accepted=2 in_ready=0", idx, in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b1 || {flags, result} !== be[0]) begin
      n_fail++;
      $display("FAIL bp_head: got ov=%b fl=%h res=%h, want ov=1 fl=%h res=%h",
               out_valid, flags, result, be[0][19:16], be[0][15:0]);
    end
    held = result;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || result !== held) begin
      n_fail++;
      $display("FAIL bp_hold: got ov=%b res=%h, want ov=1 res=%h", out_valid, result, held);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (idx < 3);
      mults = bm[idx > 2 ? 2 : idx];
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || {flags, result} !== be[k]) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got ov=%b fl=%h res=%h, want ov=1 fl=%h res=%h",
                 k, out_valid, flags, result, be[k][19:16], be[k][15:0]);
      end
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1; mults = 11'h206; multc = '0; op_a = 16'h3F80; op_b = 16'h4000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_full: got ov=%b ir=%b, want ov=1 ir=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_stale: got %0d stale beats, want 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random(400);
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
